// File: rtl/uart_rfifo_arb_pkg.sv
// Shared definitions for the UART RX FIFO read-port arbiter.
// Holds the state encoding, owner codes and the FIFO record geometry.
package uart_rfifo_arb_pkg;

    localparam int UART_FIFO_REC_WIDTH = 11;
    localparam int ARB_DATA_W          = UART_FIFO_REC_WIDTH;
    localparam int ARB_COUNT_W         = 5;
    localparam int ARB_LOCK_TOUT       = 256;
    localparam int ARB_TOUT_W          = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_C0   = 2'b01;
    localparam logic [1:0] OWNER_C1   = 2'b10;

    // A held lock narrows the eligible set to the owning core only.
    function automatic logic [1:0] eligible_reqs(input logic [1:0] owner,
                                                 input logic [1:0] reqs);
        logic [1:0] elig;
        if (owner == OWNER_NONE) begin
            elig = reqs;
        end else begin
            elig = reqs & owner;
        end
        return elig;
    endfunction

endpackage

// File: rtl/uart_rr_pick2.sv
// Two-way round-robin picker: on a tie, grants the requester that was not served last.
// last = 1'b0 means core0 was granted last, 1'b1 means core1.
module uart_rr_pick2
    import uart_rfifo_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant selection
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/uart_rfifo_arb.sv
// Arbitrates core0/core1 reads of the shared UART RX FIFO: one pop per grant,
// round-robin between cores, with an optional lock that a timeout can break.
module uart_rfifo_arb
    import uart_rfifo_arb_pkg::*;
#(
    parameter int DATA_W    = ARB_DATA_W,
    parameter int COUNT_W   = ARB_COUNT_W,
    parameter int LOCK_TOUT = ARB_LOCK_TOUT,
    parameter int TOUT_W    = ARB_TOUT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic               lock0,
    input  logic               lock1,
    output logic               ack0,
    output logic               ack1,
    output logic [DATA_W-1:0]  rdata,
    output logic               rempty,
    input  logic [COUNT_W-1:0] fifo_count,
    input  logic [DATA_W-1:0]  fifo_data,
    input  logic               fifo_reset,
    output logic               fifo_pop,
    output logic [1:0]         owner,
    output logic               lock_tout
);

    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(LOCK_TOUT - 1);
    localparam logic [TOUT_W-1:0] TOUT_ONE  = TOUT_W'(1);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [1:0]        owner_q, owner_d;
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              empty_q, empty_d;
    logic              lock_tout_q, lock_tout_d;

    logic [1:0] elig_s;
    logic [1:0] gnt_s;
    logic       pop_s;
    logic       owner_req_s;
    logic       owner_lock_s;

    assign elig_s = eligible_reqs(owner_q, {req1, req0});

    uart_rr_pick2 u_pick (
        .req  (elig_s),
        .last (last_q),
        .gnt  (gnt_s)
    );

    // Request and lock level of whichever core currently owns the port
    always_comb begin
        owner_req_s  = 1'b0;
        owner_lock_s = 1'b0;
        case (owner_q)
            OWNER_C0: begin
                owner_req_s  = req0;
                owner_lock_s = lock0;
            end
            OWNER_C1: begin
                owner_req_s  = req1;
                owner_lock_s = lock1;
            end
            default: begin
                owner_req_s  = 1'b0;
                owner_lock_s = 1'b0;
            end
        endcase
    end

    // A pop is only legal in POP with data present and no flush running
    always_comb begin
        if ((state_q == ST_POP) && (fifo_count != {COUNT_W{1'b0}}) && !fifo_reset) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every grant runs IDLE -> POP -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s != 2'b00) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP:  state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant bookkeeping, lock ownership, timeout and captured response
    always_comb begin
        grant_d     = grant_q;
        last_d      = last_q;
        owner_d     = owner_q;
        tout_d      = tout_q;
        rdata_d     = rdata_q;
        empty_d     = empty_q;
        lock_tout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s != 2'b00) begin
                    grant_d = gnt_s[1];
                    last_d  = gnt_s[1];
                    tout_d  = {TOUT_W{1'b0}};
                    if (gnt_s[1]) begin
                        owner_d = lock1 ? OWNER_C1 : OWNER_NONE;
                    end else begin
                        owner_d = lock0 ? OWNER_C0 : OWNER_NONE;
                    end
                end else if ((owner_q != OWNER_NONE) && !owner_lock_s) begin
                    owner_d = OWNER_NONE;
                    tout_d  = {TOUT_W{1'b0}};
                end else if ((owner_q != OWNER_NONE) && !owner_req_s) begin
                    // Owner is idle but keeps the lock: force release once the budget is spent
                    if (tout_q == TOUT_LAST) begin
                        owner_d     = OWNER_NONE;
                        tout_d      = {TOUT_W{1'b0}};
                        lock_tout_d = 1'b1;
                    end else begin
                        tout_d = tout_q + TOUT_ONE;
                    end
                end else begin
                    tout_d = tout_q;
                end
            end
            ST_POP: begin
                if (pop_s) begin
                    rdata_d = fifo_data;
                    empty_d = 1'b0;
                end else begin
                    rdata_d = {DATA_W{1'b0}};
                    empty_d = 1'b1;
                end
            end
            ST_RESP: begin
                rdata_d = rdata_q;
            end
            default: begin
                rdata_d = rdata_q;
            end
        endcase
    end

    // Datapath and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            owner_q     <= OWNER_NONE;
            tout_q      <= {TOUT_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            empty_q     <= 1'b0;
            lock_tout_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            tout_q      <= tout_d;
            rdata_q     <= rdata_d;
            empty_q     <= empty_d;
            lock_tout_q <= lock_tout_d;
        end
    end

    // Output decode from the registered state
    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        rempty    = 1'b0;
        rdata     = {DATA_W{1'b0}};
        fifo_pop  = pop_s;
        owner     = owner_q;
        lock_tout = lock_tout_q;
        if (state_q == ST_RESP) begin
            ack0   = !grant_q;
            ack1   = grant_q;
            rempty = empty_q;
            rdata  = rdata_q;
        end else begin
            ack0   = 1'b0;
            ack1   = 1'b0;
            rempty = 1'b0;
            rdata  = {DATA_W{1'b0}};
        end
    end

endmodule
